// File: rtl/burst_rr_arbiter_if.sv
// Beat-channel bundle shared by N requesters and one sink.
//   in_valid / in_last / in_data : per-requester beat, last-of-burst flag, data
//                                  (requester i data sits in bits [i*W +: W])
//   in_ready                     : per-requester beat accepted
//   out_valid / out_last / out_data / out_ready : single sink-side beat channel
// Modports:
//   slave  - the arbiter's view (consumes requester beats, drives the sink)
//   master - the surrounding environment's view (sources and sink)
interface burst_rr_arbiter_if #(
  parameter int N = 3,
  parameter int W = 32
);
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/burst_rr_arbiter.sv
// Round-robin burst arbiter: shares one downstream beat channel between N
// requesters. A grant is held for a whole burst (until a fire with in_last),
// then released for one idle cycle in which the next winner is chosen,
// searching from the requester after the previous owner. A watchdog forces
// release after MAX_BEATS beats without in_last and pulses err for one cycle.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - beat channel bundle (slave modport)
//   grant  - registered one-hot grant, zero when idle
//   busy   - a burst owns the channel
//   err    - one-cycle pulse after a watchdog release
module burst_rr_arbiter #(
  parameter int N         = 3,
  parameter int W         = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  burst_rr_arbiter_if.slave    bus,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic                 err
);

  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       grant_reg, grant_next;
  logic [PTR_W-1:0]   gidx_reg, gidx_next;   // index of the granted requester
  logic [PTR_W-1:0]   ptr_reg, ptr_next;     // search start for next arbitration
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic               err_reg, err_next;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic               fire;
  logic               cur_last;
  logic [PTR_W-1:0]   gidx_inc;

  // Rotating priority search starting at ptr. cand never exceeds 2N-2, so a
  // single conditional subtract is enough to wrap it back into 0..N-1.
  always_comb begin
    logic [PTR_W:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_reg} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(N)) begin
        cand = cand - (PTR_W+1)'(N);
      end
      if (!win_found && bus.in_valid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Datapath mux driven straight from the one-hot grant; everything is zero
  // while grant is zero, which keeps out_valid low in IDLE.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_reg[i]) begin
        bus.out_data = bus.in_data[i*W +: W];
      end
    end
  end

  assign bus.out_valid = |(grant_reg & bus.in_valid);
  assign bus.out_last  = |(grant_reg & bus.in_last);
  assign bus.in_ready  = grant_reg & {N{bus.out_ready}};
  assign fire          = bus.out_valid & bus.out_ready;
  assign cur_last      = bus.out_last;
  assign gidx_inc      = (gidx_reg == PTR_W'(N-1)) ? '0 : gidx_reg + PTR_W'(1);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    gidx_next     = gidx_reg;
    ptr_next      = ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next    = BUSY;
          grant_next    = N'(1) << win_idx;
          gidx_next     = win_idx;
          beat_cnt_next = '0;
        end
      end
      BUSY: begin
        if (fire) begin
          if (beat_cnt_reg != CNT_W'(MAX_BEATS)) begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
          // Watchdog compares the count before this beat is added, so the
          // MAX_BEATS-th beat without in_last is the one that forces release.
          if (cur_last || (beat_cnt_reg == CNT_W'(MAX_BEATS-1))) begin
            state_next = IDLE;
            grant_next = '0;
            ptr_next   = gidx_inc;
            err_next   = ~cur_last;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      gidx_reg     <= '0;
      ptr_reg      <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      gidx_reg     <= gidx_next;
      ptr_reg      <= ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign grant = grant_reg;
  assign busy  = (state_reg == BUSY);
  assign err   = err_reg;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
module tb_burst_rr_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [N-1:0] grant;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  burst_rr_arbiter_if #(.N(N), .W(W)) bus ();

  burst_rr_arbiter #(.N(N), .W(W), .MAX_BEATS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .grant (grant),
    .busy  (busy),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    if (obs === exp) $display("ok   %s = %h", tag, obs);
  endtask

  task automatic invariants(input string tag);
    chk({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
    chk({tag, ".ready_in_grant"}, 32'((bus.in_ready & ~grant) == '0), 32'd1);
    if (grant == '0) chk({tag, ".idle_no_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    bus.in_data[idx*W +: W] = val;
  endtask

  logic [2:0]  rr_grant [7];
  logic [31:0] rr_data  [7];
  logic [31:0] d;

  initial begin
    rr_grant = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    rr_data  = '{32'hAAAA_0000, 32'h0, 32'hBBBB_0001, 32'h0, 32'hCCCC_0002, 32'h0, 32'hAAAA_0000};

    // 1: reset held with all requesters valid
    reset         = 1'b0;
    bus.in_valid  = 3'b111;
    bus.in_last   = 3'b000;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rst%0d.grant", i), 32'(grant), 32'd0);
      chk($sformatf("rst%0d.out_valid", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("rst%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("rst%0d.err", i), 32'(err), 32'd0);
    end
    next_cyc();
    reset       = 1'b1;
    bus.in_last = 3'b111;
    set_data(0, 32'hAAAA_0000);
    set_data(1, 32'hBBBB_0001);
    set_data(2, 32'hCCCC_0002);
    @(negedge clock);
    chk("rel.grant_idle", 32'(grant), 32'd0);
    chk("rel.busy", 32'(busy), 32'd0);

    // 2: round-robin with single-beat bursts
    for (int k = 0; k < 7; k++) begin
      next_cyc();
      @(negedge clock);
      chk($sformatf("rr%0d.grant", k), 32'(grant), 32'(rr_grant[k]));
      chk($sformatf("rr%0d.out_data", k), bus.out_data, rr_data[k]);
      chk($sformatf("rr%0d.out_valid", k), 32'(bus.out_valid), 32'(rr_grant[k] != 3'b000));
      invariants($sformatf("rr%0d", k));
    end

    // 3: 4-beat burst from requester 1 with toggling out_ready
    next_cyc();
    bus.in_valid = 3'b011;
    bus.in_last  = 3'b000;
    @(negedge clock);
    chk("hold.bubble_grant", 32'(grant), 32'd0);
    for (int i = 0; i < 7; i++) begin
      next_cyc();
      bus.out_ready = (i % 2 == 0);
      bus.in_last   = (i == 6) ? 3'b010 : 3'b000;
      set_data(1, 32'h1000_0000 + 32'(i));
      @(negedge clock);
      chk($sformatf("hold%0d.grant", i), 32'(grant), 32'b010);
      chk($sformatf("hold%0d.in_ready", i), 32'(bus.in_ready), (i % 2 == 0) ? 32'b010 : 32'b000);
      chk($sformatf("hold%0d.out_data", i), bus.out_data, 32'h1000_0000 + 32'(i));
      invariants($sformatf("hold%0d", i));
    end
    next_cyc();
    bus.in_valid = 3'b001;
    bus.in_last  = 3'b000;
    @(negedge clock);
    chk("hold.release_grant", 32'(grant), 32'd0);
    chk("hold.release_err", 32'(err), 32'd0);

    // 4+5: requester 0 streams 16 beats without last, stalled 5 cycles on beat 3
    for (int j = 0; j < 21; j++) begin
      next_cyc();
      bus.out_ready = (j < 3 || j > 7);
      if (j < 3)       d = 32'hA5A5_0000 + 32'(j);
      else if (j <= 8) d = 32'hA5A5_0003;
      else             d = 32'hA5A5_0000 + 32'(j - 5);
      set_data(0, d);
      @(negedge clock);
      chk($sformatf("wd%0d.grant", j), 32'(grant), 32'b001);
      chk($sformatf("wd%0d.out_valid", j), 32'(bus.out_valid), 32'd1);
      chk($sformatf("wd%0d.out_data", j), bus.out_data, d);
      chk($sformatf("wd%0d.in_ready", j), 32'(bus.in_ready), (j < 3 || j > 7) ? 32'b001 : 32'b000);
      chk($sformatf("wd%0d.err", j), 32'(err), 32'd0);
    end
    next_cyc();
    bus.in_valid = 3'b111;
    @(negedge clock);
    chk("wd.release_grant", 32'(grant), 32'd0);
    chk("wd.err_pulse", 32'(err), 32'd1);
    next_cyc();
    bus.in_last   = 3'b010;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("wd.ptr1_grant", 32'(grant), 32'b010);
    chk("wd.err_cleared", 32'(err), 32'd0);
    chk("wd.out_data1", bus.out_data, 32'h1000_0006);

    // 6: asynchronous reset in the middle of a requester-2 burst
    next_cyc();
    bus.in_valid = 3'b100;
    bus.in_last  = 3'b000;
    @(negedge clock);
    chk("ar.bubble_grant", 32'(grant), 32'd0);
    for (int b = 0; b < 2; b++) begin
      next_cyc();
      set_data(2, 32'h2000_0000 + 32'(b));
      @(negedge clock);
      chk($sformatf("ar%0d.grant", b), 32'(grant), 32'b100);
      chk($sformatf("ar%0d.out_data", b), bus.out_data, 32'h2000_0000 + 32'(b));
    end
    next_cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("ar.async_grant", 32'(grant), 32'd0);
    chk("ar.async_busy", 32'(busy), 32'd0);
    chk("ar.async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar.async_in_ready", 32'(bus.in_ready), 32'd0);
    next_cyc();
    next_cyc();
    reset        = 1'b1;
    bus.in_valid = 3'b101;
    @(negedge clock);
    chk("ar.post_idle", 32'(grant), 32'd0);
    next_cyc();
    @(negedge clock);
    chk("ar.post_grant", 32'(grant), 32'b001);
    chk("ar.post_data", bus.out_data, 32'hA5A5_000F);
    chk("ar.post_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
